// File: rtl/psum_drain_ctrl.sv
// Drains psum vectors from the corelet output FIFO into the psum SRAM at
// consecutive addresses, counting against a programmed length.
module psum_drain_ctrl #(
   parameter int unsigned psum_bw = 16,
   parameter int unsigned col     = 8,
   parameter int unsigned addr_w  = 11,
   parameter int unsigned len_w   = 11
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [addr_w-1:0]        base_addr,
   input  logic [len_w-1:0]         num_vec,
   input  logic                     ofifo_valid,
   input  logic [psum_bw*col-1:0]   psum_in,
   output logic                     ofifo_rd,
   output logic                     sram_cen,
   output logic                     sram_wen,
   output logic [addr_w-1:0]        sram_addr,
   output logic [psum_bw*col-1:0]   sram_d,
   output logic                     busy,
   output logic                     done
);

   localparam int unsigned DW = psum_bw * col;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic              w_rd;
   logic              w_wr_last;
   logic [addr_w-1:0] r_base;
   logic [len_w-1:0]  r_num_vec;
   logic [len_w-1:0]  r_rd_cnt;
   logic [len_w-1:0]  r_wr_cnt;
   logic              r_sram_cen;
   logic              r_sram_wen;
   logic [addr_w-1:0] r_sram_addr;
   logic [DW-1:0]     r_sram_d;
   logic              r_busy;
   logic              r_done;

   // A write is in flight this cycle whenever the previous cycle popped
   assign w_wr_last = !r_sram_cen && ((r_wr_cnt + len_w'(1)) == r_num_vec);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      w_rd   = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) w_next = (num_vec == '0) ? DONE : DRAIN;
         end
         DRAIN: begin
            w_rd = ofifo_valid && (r_rd_cnt < r_num_vec);
            if (w_wr_last) w_next = DONE;
         end
         DONE: begin
            w_next = IDLE;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   // Pop in cycle t lands on the SRAM port in t+1; the address is taken from
   // the pop count, which equals the write count of that same vector.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_base      <= '0;
         r_num_vec   <= '0;
         r_rd_cnt    <= '0;
         r_wr_cnt    <= '0;
         r_sram_cen  <= 1'b1;
         r_sram_wen  <= 1'b1;
         r_sram_addr <= '0;
         r_sram_d    <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_busy     <= (w_next != IDLE);
         r_done     <= (w_next == DONE);
         r_sram_cen <= !w_rd;
         r_sram_wen <= !w_rd;
         if ((r_state == IDLE) && start) begin
            r_base    <= base_addr;
            r_num_vec <= num_vec;
            r_rd_cnt  <= '0;
            r_wr_cnt  <= '0;
         end
         if (w_rd) begin
            r_rd_cnt    <= r_rd_cnt + len_w'(1);
            r_sram_d    <= psum_in;
            r_sram_addr <= r_base + addr_w'(r_rd_cnt);
         end
         if (!r_sram_cen) r_wr_cnt <= r_wr_cnt + len_w'(1);
      end
   end

   assign ofifo_rd  = w_rd;
   assign sram_cen  = r_sram_cen;
   assign sram_wen  = r_sram_wen;
   assign sram_addr = r_sram_addr;
   assign sram_d    = r_sram_d;
   assign busy      = r_busy;
   assign done      = r_done;

endmodule

// File: tb/tb_psum_drain_ctrl.sv
// Directed bench for psum_drain_ctrl: inputs change on the falling edge,
// outputs are sampled 1ns later, expectations come from a small FIFO model.
module tb_psum_drain_ctrl;

   logic          clk;
   logic          reset;
   logic          start;
   logic [10:0]   base_addr;
   logic [10:0]   num_vec;
   logic          ofifo_valid;
   logic [127:0]  psum_in;
   logic          ofifo_rd;
   logic          sram_cen;
   logic          sram_wen;
   logic [10:0]   sram_addr;
   logic [127:0]  sram_d;
   logic          busy;
   logic          done;

   int n_chk;
   int n_pass;

   psum_drain_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .base_addr   (base_addr),
      .num_vec     (num_vec),
      .ofifo_valid (ofifo_valid),
      .psum_in     (psum_in),
      .ofifo_rd    (ofifo_rd),
      .sram_cen    (sram_cen),
      .sram_wen    (sram_wen),
      .sram_addr   (sram_addr),
      .sram_d      (sram_d),
      .busy        (busy),
      .done        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   // Distinct, lane-tagged test vector k
   function automatic logic [127:0] vec(input int k);
      logic [127:0] v;
      for (int i = 0; i < 8; i++) v[16*i +: 16] = 16'((k << 8) + (i << 4) + 3);
      return v;
   endfunction

   task automatic idle_check(input string tag);
      check({tag, "_rd"},   128'(ofifo_rd), 128'(0));
      check({tag, "_cen"},  128'(sram_cen), 128'(1));
      check({tag, "_wen"},  128'(sram_wen), 128'(1));
      check({tag, "_busy"}, 128'(busy),     128'(0));
      check({tag, "_done"}, 128'(done),     128'(0));
   endtask

   // One drain: start at cycle 0, ofifo_valid follows pat for plen cycles
   // then stays high; optional second start at rs_cyc must be ignored.
   task automatic run_drain(input string tag, input logic [10:0] base, input logic [10:0] num,
                            input logic [31:0] pat, input int plen, input int off, input int rs_cyc);
      int pops;
      int wrs;
      int exp_done;
      logic prev_pop;
      logic exp_rd;
      logic [10:0] exp_addr;
      pops     = 0;
      wrs      = 0;
      exp_done = (num == 11'd0) ? 1 : -1;
      prev_pop = 1'b0;
      for (int c = 0; c < 80; c++) begin
         @(negedge clk);
         start       = (c == 0) || (c == rs_cyc);
         base_addr   = (c == 0) ? base : base + 11'h155;
         num_vec     = (c == 0) ? num : num + 11'd3;
         ofifo_valid = (c == 0) ? 1'b1 : ((c - 1 < plen) ? pat[c-1] : 1'b1);
         psum_in     = vec(off + pops);
         #1;
         exp_rd = (c >= 1) && ofifo_valid && (pops < int'(num));
         check({tag, "_rd"},  128'(ofifo_rd), 128'(exp_rd));
         check({tag, "_cen"}, 128'(sram_cen), 128'(!prev_pop));
         check({tag, "_wen"}, 128'(sram_wen), 128'(!prev_pop));
         if (prev_pop) begin
            exp_addr = base + 11'(wrs);
            check({tag, "_addr"}, 128'(sram_addr), 128'(exp_addr));
            check({tag, "_data"}, sram_d, vec(off + wrs));
            wrs++;
            if (wrs == int'(num)) exp_done = c + 1;
         end
         check({tag, "_done"}, 128'(done), 128'(c == exp_done));
         check({tag, "_busy"}, 128'(busy), 128'((c >= 1) && (exp_done < 0 || c <= exp_done)));
         if (exp_rd) pops++;
         prev_pop = exp_rd;
         if (exp_done >= 0 && c == exp_done + 1) break;
      end
      start = 1'b0;
   endtask

   initial begin
      n_chk       = 0;
      n_pass      = 0;
      reset       = 1'b0;
      start       = 1'b0;
      base_addr   = '0;
      num_vec     = '0;
      ofifo_valid = 1'b1;
      psum_in     = vec(99);

      // Reset held, then released, with the FIFO claiming data
      repeat (2) begin
         @(negedge clk); #1;
         idle_check("rst");
         check("rst_addr", 128'(sram_addr), 128'(0));
         check("rst_d",    sram_d,          128'(0));
      end
      @(negedge clk);
      reset = 1'b1;
      repeat (3) begin
         @(negedge clk); #1;
         idle_check("post_rst");
      end

      // Back-to-back drain of 4 vectors
      run_drain("burst", 11'h010, 11'd4, 32'h0, 0, 0, -1);
      // Gapped valid pattern 1,0,0,1,1,0,1,1
      run_drain("gaps", 11'h100, 11'd5, 32'b1101_1001, 8, 20, -1);
      // Address wrap past the top of the SRAM
      run_drain("wrap", 11'h7FE, 11'd3, 32'h0, 0, 40, -1);
      // Zero-length drain
      run_drain("zero", 11'h055, 11'd0, 32'h0, 0, 60, -1);
      // Second start mid-drain is ignored
      run_drain("restart", 11'h040, 11'd3, 32'b10, 2, 70, 2);

      // Reset after 2 of 6 writes
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         start       = (c == 0);
         base_addr   = 11'h200;
         num_vec     = 11'd6;
         ofifo_valid = 1'b1;
         psum_in     = vec(80 + c);
         #1;
      end
      check("mid_cen", 128'(sram_cen), 128'(0));
      check("mid_addr", 128'(sram_addr), 128'(11'h201));
      reset = 1'b0;
      #1;
      idle_check("async_rst");
      check("async_rst_addr", 128'(sram_addr), 128'(0));
      check("async_rst_d",    sram_d,          128'(0));
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (4) begin
         @(negedge clk); #1;
         idle_check("after_rst");
      end
      run_drain("fresh", 11'h300, 11'd2, 32'h0, 0, 90, -1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
